// File: rtl/rv32i_processor_top.sv
// rtl/rv32i_processor_top.sv - 5-stage in-order RV32I integer (OP / OP-IMM) pipeline
//
// Modules:
//   rv32i_pkg        ALU operation codes
//   rv32i_imem       instruction memory; combinational read; write port tied off at top
//   rv32i_reg_file   32x32 register file; async reads; write on clk; x0 hard zero
//   rv32i_id_stage   decoder plus register file read
//   rv32i_processor_top
//     clk  in  1  rising-edge clock
//     rst  in  1  asynchronous active-low reset
// Build option: FORWARDING_EN adds EX/MEM and MEM/WB bypass muxes on the EX operands.

package rv32i_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;
endpackage

module rv32i_imem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);
    // Not reset: contents survive reset.
    logic [31:0] mem_array [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_array[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_array[raddr_i];
endmodule

module rv32i_reg_file (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    input  logic        we_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] rd_data_i
);
    logic [31:0] registers [32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we_i && (rd_i != 5'd0)) begin
            registers[rd_i] <= rd_data_i;
        end
    end

    // No write-to-read bypass: a same-cycle write is seen on the next cycle.
    assign rs1_data_o = registers[rs1_i];
    assign rs2_data_o = registers[rs2_i];
endmodule

module rv32i_id_stage
    import rv32i_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        dec_valid_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output alu_op_e     op_o,
    output logic        use_imm_o,
    output logic [31:0] imm_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o
);
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rd_o   = instr_i[11:7];
    assign rs1_o  = instr_i[19:15];
    assign rs2_o  = instr_i[24:20];
    assign imm_o  = {{20{instr_i[31]}}, instr_i[31:20]};

    rv32i_reg_file reg_file_inst (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rs1_i      (rs1_o),
        .rs2_i      (rs2_o),
        .rs1_data_o (rs1_data_o),
        .rs2_data_o (rs2_data_o),
        .we_i       (wb_we_i),
        .rd_i       (wb_rd_i),
        .rd_data_i  (wb_data_i)
    );

    // Anything not a legal OP / OP-IMM encoding leaves dec_valid_o low (bubble).
    always_comb begin
        dec_valid_o = 1'b0;
        op_o        = ALU_ADD;
        use_imm_o   = 1'b0;
        if (valid_i && opcode == 7'b0010011) begin
            use_imm_o   = 1'b1;
            dec_valid_o = 1'b1;
            case (funct3)
                3'b000:  op_o = ALU_ADD;
                3'b010:  op_o = ALU_SLT;
                3'b011:  op_o = ALU_SLTU;
                3'b100:  op_o = ALU_XOR;
                3'b110:  op_o = ALU_OR;
                3'b111:  op_o = ALU_AND;
                3'b001: begin
                    op_o        = ALU_SLL;
                    dec_valid_o = (funct7 == 7'b0000000);
                end
                default: begin
                    op_o        = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                    dec_valid_o = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end
            endcase
        end else if (valid_i && opcode == 7'b0110011) begin
            if (funct7 == 7'b0000000) begin
                dec_valid_o = 1'b1;
                case (funct3)
                    3'b000:  op_o = ALU_ADD;
                    3'b001:  op_o = ALU_SLL;
                    3'b010:  op_o = ALU_SLT;
                    3'b011:  op_o = ALU_SLTU;
                    3'b100:  op_o = ALU_XOR;
                    3'b101:  op_o = ALU_SRL;
                    3'b110:  op_o = ALU_OR;
                    default: op_o = ALU_AND;
                endcase
            end else if (funct7 == 7'b0100000) begin
                dec_valid_o = (funct3 == 3'b000) || (funct3 == 3'b101);
                op_o        = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
            end
        end
    end
endmodule

module rv32i_processor_top
    import rv32i_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic clk,
    input  logic rst
);
    localparam int AW = $clog2(IMEM_DEPTH);

    // PC kept as a word index; its width makes it wrap modulo IMEM_DEPTH*4 bytes.
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   imem_rdata;

    logic          ifid_valid_q;
    logic [31:0]   ifid_instr_q;

    logic          dec_valid, dec_use_imm;
    logic [4:0]    dec_rd, dec_rs1, dec_rs2;
    alu_op_e       dec_op;
    logic [31:0]   dec_imm, dec_rs1_data, dec_rs2_data;

    logic          idex_valid_q, idex_use_imm_q;
    logic [4:0]    idex_rd_q;
    alu_op_e       idex_op_q;
    logic [31:0]   idex_imm_q, idex_rs1_data_q, idex_rs2_data_q;

    logic [31:0]   op_a, op_b_reg, op_b, alu_res_d;

    logic          exmem_valid_q, memwb_valid_q;
    logic [4:0]    exmem_rd_q, memwb_rd_q;
    logic [31:0]   exmem_res_q, memwb_res_q;

    assign pc_d = pc_q + 1'b1;

    rv32i_imem #(.DEPTH(IMEM_DEPTH), .AW(AW)) imem_inst (
        .clk_i   (clk),
        .we_i    (1'b0),
        .waddr_i ('0),
        .wdata_i (32'h0),
        .raddr_i (pc_q),
        .rdata_o (imem_rdata)
    );

    rv32i_id_stage id_stage_inst (
        .clk_i       (clk),
        .rst_ni      (rst),
        .valid_i     (ifid_valid_q),
        .instr_i     (ifid_instr_q),
        .wb_we_i     (memwb_valid_q),
        .wb_rd_i     (memwb_rd_q),
        .wb_data_i   (memwb_res_q),
        .dec_valid_o (dec_valid),
        .rd_o        (dec_rd),
        .rs1_o       (dec_rs1),
        .rs2_o       (dec_rs2),
        .op_o        (dec_op),
        .use_imm_o   (dec_use_imm),
        .imm_o       (dec_imm),
        .rs1_data_o  (dec_rs1_data),
        .rs2_data_o  (dec_rs2_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q            <= RESET_PC[AW+1:2];
            ifid_valid_q    <= 1'b0;
            ifid_instr_q    <= '0;
            idex_valid_q    <= 1'b0;
            idex_use_imm_q  <= 1'b0;
            idex_rd_q       <= '0;
            idex_op_q       <= ALU_ADD;
            idex_imm_q      <= '0;
            idex_rs1_data_q <= '0;
            idex_rs2_data_q <= '0;
            exmem_valid_q   <= 1'b0;
            exmem_rd_q      <= '0;
            exmem_res_q     <= '0;
            memwb_valid_q   <= 1'b0;
            memwb_rd_q      <= '0;
            memwb_res_q     <= '0;
        end else begin
            pc_q            <= pc_d;
            ifid_valid_q    <= 1'b1;
            ifid_instr_q    <= imem_rdata;
            idex_valid_q    <= dec_valid;
            idex_use_imm_q  <= dec_use_imm;
            idex_rd_q       <= dec_rd;
            idex_op_q       <= dec_op;
            idex_imm_q      <= dec_imm;
            idex_rs1_data_q <= dec_rs1_data;
            idex_rs2_data_q <= dec_rs2_data;
            exmem_valid_q   <= idex_valid_q;
            exmem_rd_q      <= idex_rd_q;
            exmem_res_q     <= alu_res_d;
            memwb_valid_q   <= exmem_valid_q;
            memwb_rd_q      <= exmem_rd_q;
            memwb_res_q     <= exmem_res_q;
        end
    end

`ifdef FORWARDING_EN
    logic [4:0] idex_rs1_q, idex_rs2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_rs1_q <= '0;
            idex_rs2_q <= '0;
        end else begin
            idex_rs1_q <= dec_rs1;
            idex_rs2_q <= dec_rs2;
        end
    end

    // Younger result (EX/MEM) wins over older (MEM/WB).
    always_comb begin
        op_a = idex_rs1_data_q;
        if (exmem_valid_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs1_q)
            op_a = exmem_res_q;
        else if (memwb_valid_q && memwb_rd_q != 5'd0 && memwb_rd_q == idex_rs1_q)
            op_a = memwb_res_q;
        op_b_reg = idex_rs2_data_q;
        if (exmem_valid_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs2_q)
            op_b_reg = exmem_res_q;
        else if (memwb_valid_q && memwb_rd_q != 5'd0 && memwb_rd_q == idex_rs2_q)
            op_b_reg = memwb_res_q;
    end
`else
    assign op_a     = idex_rs1_data_q;
    assign op_b_reg = idex_rs2_data_q;
`endif

    assign op_b = idex_use_imm_q ? idex_imm_q : op_b_reg;

    always_comb begin
        alu_res_d = '0;
        case (idex_op_q)
            ALU_ADD:  alu_res_d = op_a + op_b;
            ALU_SUB:  alu_res_d = op_a - op_b;
            ALU_SLL:  alu_res_d = op_a << op_b[4:0];
            ALU_SLT:  alu_res_d = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res_d = {31'b0, op_a < op_b};
            ALU_XOR:  alu_res_d = op_a ^ op_b;
            ALU_SRL:  alu_res_d = op_a >> op_b[4:0];
            ALU_SRA:  alu_res_d = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_OR:   alu_res_d = op_a | op_b;
            ALU_AND:  alu_res_d = op_a & op_b;
            default:  alu_res_d = '0;
        endcase
    end
endmodule

// File: tb/tb_rv32i_processor_top.sv
// tb/tb_rv32i_processor_top.sv - self-checking bench for rv32i_processor_top
module tb_rv32i_processor_top;
    logic clk = 1'b0;
    logic rst = 1'b1;

    rv32i_processor_top dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0][31:0] prog;
        int               cycles;
        int               ra;
        logic [31:0]      ea;
        int               rb;
        logic [31:0]      eb;
    } vec_t;

    vec_t vt[5];

    localparam int NW = 40;
    logic [31:0] rprog [NW];
    logic [31:0] snap  [NW+1][32];
    logic        s_wr  [NW];
    logic [4:0]  s_rd  [NW];
    logic [31:0] s_res [NW];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] rf(input int i);
        return dut.id_stage_inst.reg_file_inst.registers[i];
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) dut.imem_inst.mem_array[i] = 32'h0;
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 32; i++) check(name, i, rf(i), 32'h0);
    endtask

    // ISA semantics of one instruction; wr=0 means no architectural write.
    function automatic void model_exec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                       output logic wr, output logic [4:0] rd, output logic [31:0] res);
        logic [31:0] imm;
        logic [6:0]  f7;
        logic [2:0]  f3;
        imm = {{20{ins[31]}}, ins[31:20]};
        f7  = ins[31:25];
        f3  = ins[14:12];
        rd  = ins[11:7];
        wr  = 1'b0;
        res = 32'h0;
        if (ins[6:0] == 7'h13) begin
            wr = 1'b1;
            case (f3)
                3'd0: res = a + imm;
                3'd2: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                3'd3: res = (a < imm) ? 32'd1 : 32'd0;
                3'd4: res = a ^ imm;
                3'd6: res = a | imm;
                3'd7: res = a & imm;
                3'd1: begin wr = (f7 == 7'h00); res = a << imm[4:0]; end
                default: begin
                    if (f7 == 7'h00) res = a >> imm[4:0];
                    else if (f7 == 7'h20) res = $unsigned($signed(a) >>> imm[4:0]);
                    else wr = 1'b0;
                end
            endcase
        end else if (ins[6:0] == 7'h33 && f7 == 7'h00) begin
            wr = 1'b1;
            case (f3)
                3'd0: res = a + b;
                3'd1: res = a << b[4:0];
                3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: res = (a < b) ? 32'd1 : 32'd0;
                3'd4: res = a ^ b;
                3'd5: res = a >> b[4:0];
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end else if (ins[6:0] == 7'h33 && f7 == 7'h20) begin
            if (f3 == 3'd0) begin wr = 1'b1; res = a - b; end
            if (f3 == 3'd5) begin wr = 1'b1; res = $unsigned($signed(a) >>> b[4:0]); end
        end
        if (rd == 5'd0) wr = 1'b0;
    endfunction

    // Operand visible to slot i: the state after all slots up to i-4 (older
    // writes are committed before i reads the file), optionally overridden by
    // slots i-2 / i-1 when bypassing is built in.
    function automatic logic [31:0] operand(input int i, input logic [4:0] r);
        logic [31:0] v;
        v = snap[(i >= 3) ? i - 3 : 0][r];
`ifdef FORWARDING_EN
        for (int d = 2; d >= 1; d--)
            if (i - d >= 0 && s_wr[i-d] && s_rd[i-d] == r) v = s_res[i-d];
`endif
        return v;
    endfunction

    task automatic gen_random_prog();
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        int k, s;
        for (int i = 0; i < NW; i++) begin
            k   = $urandom_range(0, 9);
            opc = (k < 4) ? 7'h13 : (k < 9) ? 7'h33 : ((k & 1) ? 7'h37 : 7'h00);
            f3  = 3'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = (opc == 7'h33) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            s   = $urandom_range(0, 5);
            f7  = (s < 3) ? 7'h00 : (s < 5) ? 7'h20 : 7'($urandom_range(0, 127));
            if (opc == 7'h13 && f3 != 3'd1 && f3 != 3'd5)
                f7 = 7'($urandom_range(0, 127));
            rprog[i] = {f7, rs2, rs1, f3, rd, opc};
        end
    endtask

    task automatic model_random_prog();
        logic [31:0] a, b;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] res;
        for (int r = 0; r < 32; r++) snap[0][r] = 32'h0;
        for (int i = 0; i < NW; i++) begin
            a = operand(i, rprog[i][19:15]);
            b = operand(i, rprog[i][24:20]);
            model_exec(rprog[i], a, b, wr, rd, res);
            s_wr[i] = wr; s_rd[i] = rd; s_res[i] = res;
            for (int r = 0; r < 32; r++) snap[i+1][r] = snap[i][r];
            if (wr) snap[i+1][rd] = res;
        end
    endtask

    initial begin
        // Directed table: hand-encoded programs with independently derived results.
        for (int t = 0; t < 5; t++) vt[t].prog = '0;
        vt[0].prog[0] = 32'h00A00293;                               // addi x5,x0,10
        vt[0].cycles = 8;  vt[0].ra = 5; vt[0].ea = 32'd10; vt[0].rb = 0; vt[0].eb = 32'd0;
        vt[1].prog[0] = 32'h00A00293; vt[1].prog[1] = 32'h01428313; // addi x6,x5,20
        vt[1].cycles = 9;  vt[1].ra = 5; vt[1].ea = 32'd10; vt[1].rb = 6;
`ifdef FORWARDING_EN
        vt[1].eb = 32'd30;
`else
        vt[1].eb = 32'd20;
`endif
        vt[2].prog[0] = 32'h00500013; vt[2].prog[1] = 32'hFFF00093; // addi x0,x0,5; addi x1,x0,-1
        vt[2].cycles = 8;  vt[2].ra = 0; vt[2].ea = 32'd0; vt[2].rb = 1; vt[2].eb = 32'hFFFFFFFF;
        vt[3].prog[0] = 32'h00300093; vt[3].prog[1] = 32'h00500113; // addi x1,3; addi x2,5
        vt[3].prog[5] = 32'h002081B3; vt[3].prog[6] = 32'h40208233; // add x3; sub x4
        vt[3].cycles = 14; vt[3].ra = 3; vt[3].ea = 32'd8; vt[3].rb = 4; vt[3].eb = 32'hFFFFFFFE;
        // Distance-3 producer is always stale: sees x1=0 (slot 3 reads before slot 0 commits).
        vt[4].prog[0] = 32'h00300093; vt[4].prog[3] = 32'h00708193; // addi x3,x1,7
        vt[4].prog[4] = 32'h00708213;                               // addi x4,x1,7 (sees 3)
        vt[4].cycles = 12; vt[4].ra = 3; vt[4].ea = 32'd7; vt[4].rb = 4; vt[4].eb = 32'd10;

        #3;
        clear_mem();
        assert_reset();
        check_all_zero("reset_state");

        for (int t = 0; t < 5; t++) begin
            clear_mem();
            for (int j = 0; j < 8; j++) dut.imem_inst.mem_array[j] = vt[t].prog[j];
            assert_reset();
            release_reset();
            run(vt[t].cycles);
            check($sformatf("vec%0d_x%0d", t, vt[t].ra), vt[t].ra, rf(vt[t].ra), vt[t].ea);
            check($sformatf("vec%0d_x%0d", t, vt[t].rb), vt[t].rb, rf(vt[t].rb), vt[t].eb);
        end

        // Latency: word 0 lands exactly at edge 5, not earlier.
        clear_mem();
        dut.imem_inst.mem_array[0] = 32'h00A00293;
        assert_reset();
        release_reset();
        run(4);
        check("latency_edge4_x5", 5, rf(5), 32'd0);
        run(1);
        check("latency_edge5_x5", 5, rf(5), 32'd10);

        // Mid-flight resets on the add/sub program; memory is preserved.
        clear_mem();
        for (int j = 0; j < 8; j++) dut.imem_inst.mem_array[j] = vt[3].prog[j];
        assert_reset();
        release_reset();
        run(3);
        rst = 1'b0;
        #1;
        check_all_zero("midrst3");
        repeat (2) @(posedge clk);
        release_reset();
        run(7);
        check("pre_rst_x1", 1, rf(1), 32'd3);
        check("pre_rst_x2", 2, rf(2), 32'd5);
        rst = 1'b0;
        #1;
        check_all_zero("midrst7");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        release_reset();
        run(14);
        check("rerun_x1", 1, rf(1), 32'd3);
        check("rerun_x2", 2, rf(2), 32'd5);
        check("rerun_x3", 3, rf(3), 32'd8);
        check("rerun_x4", 4, rf(4), 32'hFFFFFFFE);
        check("rerun_x5", 5, rf(5), 32'd0);

        // PC wrap: word 255 then word 0 executes a second time.
        clear_mem();
        dut.imem_inst.mem_array[255] = 32'h00700393;                // addi x7,x0,7
        dut.imem_inst.mem_array[0]   = 32'h00140413;                // addi x8,x8,1
        assert_reset();
        release_reset();
        run(262);
        check("wrap_x7", 7, rf(7), 32'd7);
        check("wrap_x8", 8, rf(8), 32'd2);

        // Randomized programs against the slot-level reference model.
        for (int it = 0; it < 6; it++) begin
            gen_random_prog();
            model_random_prog();
            clear_mem();
            for (int j = 0; j < NW; j++) dut.imem_inst.mem_array[j] = rprog[j];
            assert_reset();
            release_reset();
            run(NW + 8);
            for (int r = 0; r < 32; r++)
                check($sformatf("rand%0d_x", it), r, rf(r), snap[NW][r]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
